fcore_instruction_fetch: RTL and testbench
==========================================

# fcore_instruction_fetch

Program store and fetch stage feeding the fCore control unit. It accepts a program image over a valid/ready load stream while the core is idle, records the program length, and on every enabled cycle returns the instruction pair {mem[pc+1], mem[pc]} as one wide word. The control unit uses this word for opcode dispatch and for LDC constant extraction. It also consumes `program_size` for its fault check.

## Interface
Parameters:
- PC_WIDTH, 12: program counter width; memory depth is 2**PC_WIDTH words.
- INSTRUCTION_WIDTH, 32: instruction word width.

Ports:
- clock  in  1  single clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- load_data  in  INSTRUCTION_WIDTH  program word.
- load_valid  in  1  load word valid.
- load_last  in  1  marks final word of image.
- load_ready  out  1  load word accepted when valid & ready.
- fetch_enable  in  1  core running; driven from decoder_enable.
- program_counter  in  PC_WIDTH  fetch address.
- wide_instruction  out  2*INSTRUCTION_WIDTH  {instr(pc+1), instr(pc)}.
- program_size  out  16  words in last completed image.
- load_done  out  1  one-cycle pulse at image completion.
- load_error  out  1  sticky: image exceeded memory depth.

## Operation
- Load FSM states: IDLE, LOAD, COMMIT.
- IDLE:
  - load_ready = ~fetch_enable.
  - The first accepted word is written to address 0, the write pointer becomes 1, and the FSM goes to LOAD.
  - If that first word carries load_last, the FSM goes to COMMIT instead.
- LOAD:
  - load_ready = 1 regardless of fetch_enable.
  - Each accepted word is written at the write pointer, and the pointer increments.
  - A word with load_last goes to COMMIT.
- Overflow:
  - Words accepted with write pointer == 2**PC_WIDTH are dropped (not written), and load_error is set.
  - load_ready stays 1 so the source can drain through load_last.
- COMMIT (one cycle):
  - program_size <= write pointer, saturated at 2**PC_WIDTH.
  - load_done = 1, write pointer cleared, next state IDLE.
  - load_ready = 0.
- load_error clears only on reset or on the first accepted word of a new image.
- Fetch path (enabled when fetch_enable = 1 and FSM in IDLE):
  - The lower half is mem[program_counter].
  - The upper half is mem[program_counter+1].
  - Any address >= program_size, including the wrap at pc = 2**PC_WIDTH-1, returns 0 (NOP). This guarantees LDC look-ahead never returns stale data past the image end.
- fetch_enable = 0, or FSM not in IDLE: wide_instruction holds its last value.
- Memory is implemented as two read ports (or even/odd banks) so both halves are read in one cycle. Contents are never cleared by reset.

## Timing
- Reset values (asynchronous):
  - FSM = IDLE, write pointer = 0.
  - program_size = 0, load_done = 0, load_error = 0.
  - wide_instruction = 0, load_ready = 0 (it follows the combinational rule after the reset edge).
- Read latency is 1 cycle: program_counter sampled at edge N appears on wide_instruction after edge N. This matches the control unit's opcode-compare timing.
- Write is 1 cycle per accepted word; there is no bubble between consecutive words.
- The new program_size is visible in the same cycle as load_done. Fetches after that cycle use the new size.
- fetch_enable rising while in LOAD has no effect on the load; fetch output holds until COMMIT completes.
- load_valid during COMMIT is not accepted (load_ready = 0).
- Reset mid-load:
  - The FSM returns to IDLE and program_size returns to 0, so all fetches return 0 until a complete image is loaded.
  - Partially written memory words remain but are unreachable.

## Test plan
- Load 4 words 0x11,0x22,0x33,0x44 (last on 0x44), then fetch pc = 0,1,2,3:
  - load_done pulses once and program_size = 4.
  - wide_instruction = {0x22,0x11}, {0x33,0x22}, {0x44,0x33}, {0,0x44}, each one cycle after its pc.
- Single-word image 0xAB with load_last on the first word:
  - COMMIT is reached directly and program_size = 1.
  - pc = 0 returns {0,0xAB}; pc = 1 returns {0,0}.
- With PC_WIDTH = 3, stream 10 words:
  - Words 9 and 10 are dropped and load_error = 1.
  - program_size = 8; pc = 7 returns {0, word8}.
- Hold fetch_enable = 1 in IDLE with load_valid = 1:
  - load_ready = 0 and no write occurs.
  - Drop fetch_enable: the word is accepted next cycle.
- Assert reset low for 1 cycle after 3 of 5 words:
  - program_size = 0 and fetch pc = 0 returns 0.
  - A fresh 2-word image loads correctly with program_size = 2.
- Toggle fetch_enable 1→0 with pc changing:
  - wide_instruction holds its last value while disabled.
  - It updates one cycle after re-enable.

Source files
------------

// File: rtl/fcore_instruction_fetch.sv
// Program store and fetch stage for the fCore control unit: loads a program image over a
// valid/ready stream and returns {mem[pc+1], mem[pc]} one cycle after each enabled fetch.
module fcore_instruction_fetch #(
    parameter int PC_WIDTH          = 12,
    parameter int INSTRUCTION_WIDTH = 32
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [INSTRUCTION_WIDTH-1:0]   load_data,
    input  logic                           load_valid,
    input  logic                           load_last,
    output logic                           load_ready,
    input  logic                           fetch_enable,
    input  logic [PC_WIDTH-1:0]            program_counter,
    output logic [2*INSTRUCTION_WIDTH-1:0] wide_instruction,
    output logic [15:0]                    program_size,
    output logic                           load_done,
    output logic                           load_error
);

    // Pointer/size width carries one extra bit so a completely full memory is representable.
    localparam int                PTR_WIDTH = PC_WIDTH + 1;
    localparam int                DEPTH     = 2 ** PC_WIDTH;
    localparam logic [PTR_WIDTH-1:0] DEPTH_PTR = {1'b1, {PC_WIDTH{1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_COMMIT
    } load_state_t;

    load_state_t r_state;
    load_state_t w_state_next;

    logic [INSTRUCTION_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_WIDTH-1:0]         r_wr_ptr;
    logic [PTR_WIDTH-1:0]         r_size;
    logic                         r_load_done;
    logic                         r_load_error;
    logic [2*INSTRUCTION_WIDTH-1:0] r_wide;

    logic                         w_ready;
    logic                         w_first_word;
    logic                         w_accept;
    logic                         w_overflow;
    logic                         w_write_en;
    logic [PC_WIDTH-1:0]          w_write_addr;
    logic                         w_fetch;
    logic [PTR_WIDTH-1:0]         w_pc_lo;
    logic [PTR_WIDTH-1:0]         w_pc_hi;
    logic [INSTRUCTION_WIDTH-1:0] w_instr_lo;
    logic [INSTRUCTION_WIDTH-1:0] w_instr_hi;
    logic [PTR_WIDTH-1:0]         w_size_next;

    // ------------------------------------------------------------------
    // Load FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            // NOTE: sequential state always uses non-blocking assignment so every
            // register samples pre-edge values regardless of statement order.
            r_state <= w_state_next;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through the case leaves a signal unassigned,
        // which would otherwise infer a latch.
        w_state_next = r_state;
        w_ready      = 1'b0;
        w_first_word = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_ready = ~fetch_enable;
                if (load_valid && w_ready) begin
                    w_first_word = 1'b1;
                    w_state_next = load_last ? ST_COMMIT : ST_LOAD;
                end
            end
            ST_LOAD: begin
                // Stays ready even when overflowing so the source can drain to load_last.
                w_ready = 1'b1;
                if (load_valid && load_last) begin
                    w_state_next = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign load_ready   = w_ready & reset;
    assign w_accept     = load_valid & w_ready;
    assign w_overflow   = w_accept && (r_wr_ptr == DEPTH_PTR);
    assign w_write_en   = w_accept & ~w_overflow;
    assign w_write_addr = r_wr_ptr[PC_WIDTH-1:0];
    assign w_size_next  = (r_wr_ptr > DEPTH_PTR) ? DEPTH_PTR : r_wr_ptr;

    // ------------------------------------------------------------------
    // Write pointer, commit and error tracking
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr     <= '0;
            r_size       <= '0;
            r_load_done  <= 1'b0;
            r_load_error <= 1'b0;
        end else begin
            r_load_done <= (r_state == ST_COMMIT);
            if (r_state == ST_COMMIT) begin
                r_wr_ptr <= '0;
                r_size   <= w_size_next;
            end else if (w_write_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_first_word) begin
                r_load_error <= 1'b0;
            end else if (w_overflow) begin
                r_load_error <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Program memory: one write port, two combinational read ports
    // ------------------------------------------------------------------
    // NOTE: the memory array has no reset; clearing thousands of words is costly and
    // unnecessary because reads beyond program_size are masked to zero anyway.
    always_ff @(posedge clock) begin
        if (w_write_en) begin
            r_mem[w_write_addr] <= load_data;
        end
    end

    // ------------------------------------------------------------------
    // Fetch path
    // ------------------------------------------------------------------
    assign w_fetch = fetch_enable && (r_state == ST_IDLE);
    assign w_pc_lo = {1'b0, program_counter};
    // pc = DEPTH-1 yields w_pc_hi = DEPTH, which always fails the size check below.
    assign w_pc_hi = w_pc_lo + 1'b1;

    always_comb begin
        w_instr_lo = '0;
        w_instr_hi = '0;
        if (w_pc_lo < r_size) begin
            w_instr_lo = r_mem[program_counter];
        end
        if (w_pc_hi < r_size) begin
            w_instr_hi = r_mem[w_pc_hi[PC_WIDTH-1:0]];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wide <= '0;
        end else if (w_fetch) begin
            r_wide <= {w_instr_hi, w_instr_lo};
        end
    end

    assign wide_instruction = r_wide;
    assign program_size     = 16'(r_size);
    assign load_done        = r_load_done;
    assign load_error       = r_load_error;

endmodule

// File: tb/tb_fcore_instruction_fetch.sv
// Directed bench for fcore_instruction_fetch: a default-size instance for the load/fetch
// scenarios and a PC_WIDTH=3 instance for overflow and image-boundary behaviour.
module tb_fcore_instruction_fetch;

    localparam int IW   = 32;
    localparam int PCW  = 12;
    localparam int SPCW = 3;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset;

    logic [IW-1:0]   load_data;
    logic            load_valid, load_last, load_ready, fetch_enable;
    logic [PCW-1:0]  program_counter;
    logic [2*IW-1:0] wide_instruction;
    logic [15:0]     program_size;
    logic            load_done, load_error;

    logic [IW-1:0]   s_load_data;
    logic            s_load_valid, s_load_last, s_load_ready, s_fetch_enable;
    logic [SPCW-1:0] s_program_counter;
    logic [2*IW-1:0] s_wide_instruction;
    logic [15:0]     s_program_size;
    logic            s_load_done, s_load_error;

    int tests_run    = 0;
    int tests_failed = 0;
    int done_cnt     = 0;

    logic [IW-1:0]   img [16];
    logic [2*IW-1:0] obs;
    bit              ready_ok;

    fcore_instruction_fetch #(.PC_WIDTH(PCW), .INSTRUCTION_WIDTH(IW)) u_dut (
        .clock            (clock),
        .reset            (reset),
        .load_data        (load_data),
        .load_valid       (load_valid),
        .load_last        (load_last),
        .load_ready       (load_ready),
        .fetch_enable     (fetch_enable),
        .program_counter  (program_counter),
        .wide_instruction (wide_instruction),
        .program_size     (program_size),
        .load_done        (load_done),
        .load_error       (load_error)
    );

    fcore_instruction_fetch #(.PC_WIDTH(SPCW), .INSTRUCTION_WIDTH(IW)) u_dut_small (
        .clock            (clock),
        .reset            (reset),
        .load_data        (s_load_data),
        .load_valid       (s_load_valid),
        .load_last        (s_load_last),
        .load_ready       (s_load_ready),
        .fetch_enable     (s_fetch_enable),
        .program_counter  (s_program_counter),
        .wide_instruction (s_wide_instruction),
        .program_size     (s_program_size),
        .load_done        (s_load_done),
        .load_error       (s_load_error)
    );

    always @(negedge clock) if (load_done === 1'b1) done_cnt++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Streams img[0..n-1] into the main instance back to back; leaves the FSM in COMMIT.
    task automatic load_main(input int n, output bit ok);
        ok = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            load_data  = img[i];
            load_valid = 1'b1;
            load_last  = (i == n - 1);
            #1;
            if (load_ready !== 1'b1) ok = 1'b0;
        end
        @(negedge clock);
        load_valid = 1'b0;
        load_last  = 1'b0;
        load_data  = '0;
    endtask

    task automatic load_small(input int n, output bit ok);
        ok = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            s_load_data  = img[i];
            s_load_valid = 1'b1;
            s_load_last  = (i == n - 1);
            #1;
            if (s_load_ready !== 1'b1) ok = 1'b0;
        end
        @(negedge clock);
        s_load_valid = 1'b0;
        s_load_last  = 1'b0;
        s_load_data  = '0;
    endtask

    task automatic fetch_main(input logic [PCW-1:0] pc, output logic [2*IW-1:0] o);
        @(negedge clock);
        fetch_enable    = 1'b1;
        program_counter = pc;
        @(negedge clock);
        o = wide_instruction;
    endtask

    task automatic fetch_small(input logic [SPCW-1:0] pc, output logic [2*IW-1:0] o);
        @(negedge clock);
        s_fetch_enable    = 1'b1;
        s_program_counter = pc;
        @(negedge clock);
        o = s_wide_instruction;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        load_data = '0; load_valid = 1'b0; load_last = 1'b0;
        fetch_enable = 1'b0; program_counter = '0;
        s_load_data = '0; s_load_valid = 1'b0; s_load_last = 1'b0;
        s_fetch_enable = 1'b0; s_program_counter = '0;
        repeat (3) @(negedge clock);
        tests_run++;
        if (wide_instruction !== '0) begin tests_failed++;
            $display("FAIL reset_wide: got %h expected 0", wide_instruction); end
        tests_run++;
        if (program_size !== 16'd0 || load_done !== 1'b0 || load_error !== 1'b0) begin tests_failed++;
            $display("FAIL reset_status: size=%0d done=%b err=%b expected 0/0/0", program_size, load_done, load_error); end
        tests_run++;
        if (load_ready !== 1'b0) begin tests_failed++;
            $display("FAIL reset_ready: got %b expected 0", load_ready); end
        reset = 1'b1;
        #1;
        tests_run++;
        if (load_ready !== 1'b1 || s_load_ready !== 1'b1) begin tests_failed++;
            $display("FAIL idle_ready: got %b/%b expected 1/1", load_ready, s_load_ready); end
    endtask

    task automatic test_load_fetch();
        int d0;
        d0 = done_cnt;
        img[0] = 32'h11; img[1] = 32'h22; img[2] = 32'h33; img[3] = 32'h44;
        load_main(4, ready_ok);
        repeat (3) @(negedge clock);
        tests_run++;
        if (!ready_ok) begin tests_failed++;
            $display("FAIL load4_ready: ready dropped during back-to-back load"); end
        tests_run++;
        if (done_cnt - d0 != 1) begin tests_failed++;
            $display("FAIL load4_done_pulses: got %0d expected 1", done_cnt - d0); end
        tests_run++;
        if (program_size !== 16'd4) begin tests_failed++;
            $display("FAIL load4_size: got %0d expected 4", program_size); end
        fetch_main(0, obs);
        tests_run++;
        if (obs !== {32'h22, 32'h11}) begin tests_failed++; $display("FAIL fetch_pc0: got %h expected %h", obs, {32'h22, 32'h11}); end
        fetch_main(1, obs);
        tests_run++;
        if (obs !== {32'h33, 32'h22}) begin tests_failed++; $display("FAIL fetch_pc1: got %h expected %h", obs, {32'h33, 32'h22}); end
        fetch_main(2, obs);
        tests_run++;
        if (obs !== {32'h44, 32'h33}) begin tests_failed++; $display("FAIL fetch_pc2: got %h expected %h", obs, {32'h44, 32'h33}); end
        fetch_main(3, obs);
        tests_run++;
        if (obs !== {32'h0, 32'h44}) begin tests_failed++; $display("FAIL fetch_pc3_end: got %h expected %h", obs, {32'h0, 32'h44}); end
        @(negedge clock);
        fetch_enable = 1'b0;
    endtask

    task automatic test_single_word();
        @(negedge clock);
        load_data = 32'hAB; load_valid = 1'b1; load_last = 1'b1;
        @(negedge clock);
        // FSM is in COMMIT: a held word must not be taken.
        load_data = 32'hCD;
        #1;
        tests_run++;
        if (load_ready !== 1'b0) begin tests_failed++; $display("FAIL commit_ready: got %b expected 0", load_ready); end
        tests_run++;
        if (load_done !== 1'b0 || program_size !== 16'd4) begin tests_failed++;
            $display("FAIL commit_pre_done: done=%b size=%0d expected 0/4", load_done, program_size); end
        @(negedge clock);
        load_valid = 1'b0; load_last = 1'b0; load_data = '0;
        tests_run++;
        if (load_done !== 1'b1 || program_size !== 16'd1) begin tests_failed++;
            $display("FAIL single_done_size: done=%b size=%0d expected 1/1", load_done, program_size); end
        fetch_main(0, obs);
        tests_run++;
        if (obs !== {32'h0, 32'hAB}) begin tests_failed++; $display("FAIL single_pc0: got %h expected %h", obs, {32'h0, 32'hAB}); end
        fetch_main(1, obs);
        tests_run++;
        if (obs !== 64'h0) begin tests_failed++; $display("FAIL single_pc1: got %h expected 0", obs); end
    endtask

    task automatic test_fetch_blocks_load();
        @(negedge clock);
        fetch_enable = 1'b1; program_counter = 0;
        load_data = 32'h55; load_valid = 1'b1; load_last = 1'b1;
        #1;
        tests_run++;
        if (load_ready !== 1'b0) begin tests_failed++; $display("FAIL fetch_block_ready: got %b expected 0", load_ready); end
        repeat (2) @(negedge clock);
        tests_run++;
        if (wide_instruction !== {32'h0, 32'hAB}) begin tests_failed++;
            $display("FAIL fetch_block_nowrite: got %h expected %h", wide_instruction, {32'h0, 32'hAB}); end
        fetch_enable = 1'b0;
        #1;
        tests_run++;
        if (load_ready !== 1'b1) begin tests_failed++; $display("FAIL fetch_drop_ready: got %b expected 1", load_ready); end
        @(negedge clock);
        load_valid = 1'b0; load_last = 1'b0; load_data = '0;
        @(negedge clock);
        tests_run++;
        if (program_size !== 16'd1 || load_done !== 1'b1) begin tests_failed++;
            $display("FAIL fetch_drop_commit: size=%0d done=%b expected 1/1", program_size, load_done); end
        fetch_main(0, obs);
        tests_run++;
        if (obs !== {32'h0, 32'h55}) begin tests_failed++; $display("FAIL fetch_drop_word: got %h expected %h", obs, {32'h0, 32'h55}); end
    endtask

    task automatic test_fetch_during_load();
        @(negedge clock);
        fetch_enable = 1'b0;
        load_data = 32'h81; load_valid = 1'b1; load_last = 1'b0;
        @(negedge clock);
        load_data = 32'h82; fetch_enable = 1'b1; program_counter = 1;
        #1;
        tests_run++;
        if (load_ready !== 1'b1) begin tests_failed++; $display("FAIL load_fe_ready: got %b expected 1", load_ready); end
        @(negedge clock);
        load_data = 32'h83; load_last = 1'b1;
        @(negedge clock);
        load_valid = 1'b0; load_last = 1'b0; load_data = '0;
        tests_run++;
        if (wide_instruction !== {32'h0, 32'h55}) begin tests_failed++;
            $display("FAIL load_fe_hold: got %h expected %h", wide_instruction, {32'h0, 32'h55}); end
        @(negedge clock);
        tests_run++;
        if (program_size !== 16'd3) begin tests_failed++; $display("FAIL load_fe_size: got %0d expected 3", program_size); end
        @(negedge clock);
        tests_run++;
        if (wide_instruction !== {32'h83, 32'h82}) begin tests_failed++;
            $display("FAIL load_fe_resume: got %h expected %h", wide_instruction, {32'h83, 32'h82}); end
    endtask

    task automatic test_fetch_hold();
        fetch_main(0, obs);
        tests_run++;
        if (obs !== {32'h82, 32'h81}) begin tests_failed++; $display("FAIL hold_pre: got %h expected %h", obs, {32'h82, 32'h81}); end
        @(negedge clock);
        fetch_enable = 1'b0; program_counter = 2;
        repeat (2) @(negedge clock);
        tests_run++;
        if (wide_instruction !== {32'h82, 32'h81}) begin tests_failed++;
            $display("FAIL hold_disabled: got %h expected %h", wide_instruction, {32'h82, 32'h81}); end
        fetch_enable = 1'b1;
        @(negedge clock);
        tests_run++;
        if (wide_instruction !== {32'h0, 32'h83}) begin tests_failed++;
            $display("FAIL hold_reenable: got %h expected %h", wide_instruction, {32'h0, 32'h83}); end
        fetch_enable = 1'b0;
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 10; i++) img[i] = 32'h101 + i;
        load_small(10, ready_ok);
        @(negedge clock);
        tests_run++;
        if (!ready_ok) begin tests_failed++; $display("FAIL ovf_ready: ready dropped while draining"); end
        tests_run++;
        if (s_load_error !== 1'b1) begin tests_failed++; $display("FAIL ovf_error: got %b expected 1", s_load_error); end
        tests_run++;
        if (s_program_size !== 16'd8) begin tests_failed++; $display("FAIL ovf_size: got %0d expected 8", s_program_size); end
        fetch_small(7, obs);
        tests_run++;
        if (obs !== {32'h0, 32'h108}) begin tests_failed++; $display("FAIL ovf_pc7_wrap: got %h expected %h", obs, {32'h0, 32'h108}); end
        fetch_small(6, obs);
        tests_run++;
        if (obs !== {32'h108, 32'h107}) begin tests_failed++; $display("FAIL ovf_pc6: got %h expected %h", obs, {32'h108, 32'h107}); end
        fetch_small(0, obs);
        tests_run++;
        if (obs !== {32'h102, 32'h101}) begin tests_failed++; $display("FAIL ovf_pc0_nodrop: got %h expected %h", obs, {32'h102, 32'h101}); end
        @(negedge clock);
        s_fetch_enable = 1'b0;
    endtask

    task automatic test_error_clear();
        img[0] = 32'h201; img[1] = 32'h202;
        load_small(2, ready_ok);
        @(negedge clock);
        tests_run++;
        if (s_load_error !== 1'b0 || s_program_size !== 16'd2) begin tests_failed++;
            $display("FAIL err_clear: err=%b size=%0d expected 0/2", s_load_error, s_program_size); end
        fetch_small(1, obs);
        tests_run++;
        if (obs !== {32'h0, 32'h202}) begin tests_failed++; $display("FAIL small_pc1_end: got %h expected %h", obs, {32'h0, 32'h202}); end
        fetch_small(2, obs);
        tests_run++;
        if (obs !== 64'h0) begin tests_failed++; $display("FAIL small_stale_pc2: got %h expected 0", obs); end
        @(negedge clock);
        s_fetch_enable = 1'b0;
    endtask

    task automatic test_reset_mid_load();
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            load_data = 32'h61 + i; load_valid = 1'b1; load_last = 1'b0;
        end
        @(negedge clock);
        load_valid = 1'b0; load_data = '0;
        reset = 1'b0;
        #1;
        tests_run++;
        if (program_size !== 16'd0 || wide_instruction !== '0 || load_ready !== 1'b0) begin tests_failed++;
            $display("FAIL midreset_state: size=%0d wide=%h ready=%b expected 0/0/0", program_size, wide_instruction, load_ready); end
        @(negedge clock);
        reset = 1'b1;
        fetch_main(0, obs);
        tests_run++;
        if (obs !== 64'h0) begin tests_failed++; $display("FAIL midreset_fetch: got %h expected 0", obs); end
        @(negedge clock);
        fetch_enable = 1'b0;
        img[0] = 32'h71; img[1] = 32'h72;
        load_main(2, ready_ok);
        @(negedge clock);
        tests_run++;
        if (program_size !== 16'd2 || !ready_ok) begin tests_failed++;
            $display("FAIL fresh_size: size=%0d ready_ok=%b expected 2/1", program_size, ready_ok); end
        fetch_main(0, obs);
        tests_run++;
        if (obs !== {32'h72, 32'h71}) begin tests_failed++; $display("FAIL fresh_pc0: got %h expected %h", obs, {32'h72, 32'h71}); end
        fetch_main(1, obs);
        tests_run++;
        if (obs !== {32'h0, 32'h72}) begin tests_failed++; $display("FAIL fresh_pc1: got %h expected %h", obs, {32'h0, 32'h72}); end
        @(negedge clock);
        fetch_enable = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load_fetch();
        test_single_word();
        test_fetch_blocks_load();
        test_fetch_during_load();
        test_fetch_hold();
        test_overflow();
        test_error_clear();
        test_reset_mid_load();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
